// File: rtl/axi_resp_fifo.sv
// Single-clock show-ahead FIFO for AXI B/R response bundles, with occupancy count and almost-full.
// Define AXI_FIFO_ERR_FLAG_EN to add sticky overflow/underflow flags (err_ovf/err_udf ports).
module axi_resp_fifo #(
  parameter int DATA_W    = 6,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     w_push,
  input  logic [DATA_W-1:0]        w_data,
  output logic                     w_full,
  output logic                     w_almost_full,
  input  logic                     r_pop,
  output logic [DATA_W-1:0]        r_data,
  output logic                     r_empty,
  output logic [$clog2(DEPTH):0]   count
`ifdef AXI_FIFO_ERR_FLAG_EN
  ,
  output logic                     err_ovf,
  output logic                     err_udf
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
  localparam logic [AW:0] AF_TH   = (AW + 1)'(AF_THRESH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wp_q, wp_d;
  logic [AW:0]       rp_q, rp_d;
  logic [AW:0]       count_q, count_d;
  logic              write_en;
  logic              read_en;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  assign r_empty       = (wp_q == rp_q);
  assign w_full        = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
  assign w_almost_full = (count_q >= AF_TH);
  assign r_data        = mem_q[rp_q[AW-1:0]];
  assign count         = count_q;

  assign write_en = w_push && !w_full;
  assign read_en  = r_pop && !r_empty;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (write_en) begin
      wp_d = wp_q + PTR_ONE;
    end
    if (read_en) begin
      rp_d = rp_q + PTR_ONE;
    end
    if (write_en && !read_en) begin
      count_d = count_q + PTR_ONE;
    end else if (read_en && !write_en) begin
      count_d = count_q - PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Storage is cleared on reset so r_data reads zero while empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (write_en) begin
      mem_q[wp_q[AW-1:0]] <= w_data;
    end
  end

`ifdef AXI_FIFO_ERR_FLAG_EN
  logic err_ovf_q, err_ovf_d;
  logic err_udf_q, err_udf_d;

  always_comb begin
    err_ovf_d = err_ovf_q | (w_push & w_full);
    err_udf_d = err_udf_q | (r_pop & r_empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;
`endif

endmodule
